// File: rtl/stopwatch_bcd.sv
// Seconds stopwatch with packed BCD output and debounced start/clear buttons.
// Optional lap hold display enabled by defining LAP_HOLD_EN.
module stopwatch_bcd_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                cnt   <= '0;
                // only the falling (pressed) flip is reported
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module stopwatch_bcd #(
    parameter int CLK_HZ          = 12000000,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int MAX_TENS        = 5
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       BTN_START_n,
    input  logic       BTN_CLR_n,
`ifdef LAP_HOLD_EN
    input  logic       BTN_LAP_n,
`endif
    output logic [7:0] BCD_OUT,
    output logic       RUNNING,
    output logic       TICK
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [3:0] TENS_LAST = 4'(MAX_TENS);

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          start_press;
    logic          clr_press;
    logic          clr_cnt;
    logic          cnt_en;
    logic [PW-1:0] presc;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic          tick;
    logic          running;

    stopwatch_bcd_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk   (CLK),
        .rst_n (RST_n),
        .btn_n (BTN_START_n),
        .press (start_press)
    );

    stopwatch_bcd_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk   (CLK),
        .rst_n (RST_n),
        .btn_n (BTN_CLR_n),
        .press (clr_press)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= STOP;
        end else begin
            state <= next_state;
        end
    end

    // clear is applied first; start is judged against the original state
    always_comb begin
        next_state = state;
        unique case (state)
            STOP: begin
                if (start_press) next_state = RUN;
            end
            RUN: begin
                if (start_press && !clr_press) next_state = PAUSE;
            end
            PAUSE: begin
                if (start_press) next_state = RUN;
                else if (clr_press) next_state = STOP;
            end
            default: next_state = STOP;
        endcase
    end

    always_comb begin
        clr_cnt = clr_press;
        cnt_en  = (state == RUN) && !start_press && !clr_press;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            presc   <= '0;
            tens    <= 4'd0;
            ones    <= 4'd0;
            tick    <= 1'b0;
            running <= 1'b0;
        end else begin
            tick    <= 1'b0;
            running <= (next_state == RUN);
            if (clr_cnt) begin
                presc <= '0;
                tens  <= 4'd0;
                ones  <= 4'd0;
            end else if (cnt_en) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    tick  <= 1'b1;
                    if (ones == 4'd9) begin
                        ones <= 4'd0;
                        tens <= (tens == TENS_LAST) ? 4'd0 : tens + 4'd1;
                    end else begin
                        ones <= ones + 4'd1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

`ifdef LAP_HOLD_EN
    logic       lap_press;
    logic       lap_en;
    logic       hold;
    logic [7:0] hold_val;

    stopwatch_bcd_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk   (CLK),
        .rst_n (RST_n),
        .btn_n (BTN_LAP_n),
        .press (lap_press)
    );

    assign lap_en = lap_press && (state == RUN);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            hold     <= 1'b0;
            hold_val <= 8'h00;
        end else if (clr_cnt) begin
            hold <= 1'b0;
        end else if (lap_en) begin
            hold <= ~hold;
            if (!hold) hold_val <= {tens, ones};
        end
    end

    assign BCD_OUT = hold ? hold_val : {tens, ones};
`else
    assign BCD_OUT = {tens, ones};
`endif

    assign RUNNING = running;
    assign TICK    = tick;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with CLK_HZ=10, DEBOUNCE_CYCLES=4.
// Lap-hold steps are compiled only when LAP_HOLD_EN is defined.
module tb_stopwatch_bcd;
    logic       CLK;
    logic       RST_n;
    logic       BTN_START_n;
    logic       BTN_CLR_n;
`ifdef LAP_HOLD_EN
    logic       BTN_LAP_n;
`endif
    logic [7:0] BCD_OUT;
    logic       RUNNING;
    logic       TICK;

    int n_cmp;
    int n_bad;
    int ntick;

    stopwatch_bcd #(
        .CLK_HZ          (10),
        .DEBOUNCE_CYCLES (4),
        .MAX_TENS        (5)
    ) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .BTN_START_n (BTN_START_n),
        .BTN_CLR_n   (BTN_CLR_n),
`ifdef LAP_HOLD_EN
        .BTN_LAP_n   (BTN_LAP_n),
`endif
        .BCD_OUT     (BCD_OUT),
        .RUNNING     (RUNNING),
        .TICK        (TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] bcd,
                           input logic run, input logic tk);
        chk({tag, ".bcd"}, BCD_OUT, bcd);
        chk({tag, ".run"}, 8'(RUNNING), 8'(run));
        chk({tag, ".tick"}, 8'(TICK), 8'(tk));
    endtask

    initial begin
        int v;
        logic [7:0] eb;
        n_cmp = 0;
        n_bad = 0;
        ntick = 0;
        RST_n = 1'b0;
        BTN_START_n = 1'b1;
        BTN_CLR_n = 1'b1;
`ifdef LAP_HOLD_EN
        BTN_LAP_n = 1'b1;
`endif
        step(3);
        chk_all("in_reset", 8'h00, 1'b0, 1'b0);
        RST_n = 1'b1;
        step(2);
        chk_all("after_reset", 8'h00, 1'b0, 1'b0);

        // 3-cycle glitch must not register
        BTN_START_n = 1'b0;
        step(3);
        BTN_START_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("glitch.run", 8'(RUNNING), 8'h00);
        end

        // clean press: RUNNING rises 7 edges after the edge
        BTN_START_n = 1'b0;
        step(6);
        chk("press.run6", 8'(RUNNING), 8'h00);
        step(1);
        chk_all("press.run7", 8'h00, 1'b1, 1'b0);
        BTN_START_n = 1'b1;

        // full 00..59 -> 00 sweep
        ntick = 0;
        for (int k = 1; k <= 600; k++) begin
            step(1);
            v = (k / 10) % 60;
            eb = {4'(v / 10), 4'(v % 10)};
            chk("sweep.bcd", BCD_OUT, eb);
            chk("sweep.tick", 8'(TICK), 8'((k % 10) == 0));
            if (TICK) ntick++;
        end
        chk("sweep.ticks", 8'(ntick), 8'd60);

        // pause at 07 with prescaler 4, then resume
        step(68);
        chk("pre_pause", BCD_OUT, 8'h06);
        BTN_START_n = 1'b0;
        step(6);
        chk("pre_pause2", BCD_OUT, 8'h07);
        BTN_START_n = 1'b1;
        step(1);
        chk_all("paused", 8'h07, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("hold.bcd", BCD_OUT, 8'h07);
            chk("hold.tick", 8'(TICK), 8'h00);
        end
        BTN_START_n = 1'b0;
        step(6);
        BTN_START_n = 1'b1;
        step(1);
        chk_all("resumed", 8'h07, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("resume.notick", 8'(TICK), 8'h00);
        end
        step(1);
        chk_all("resume.tick6", 8'h08, 1'b1, 1'b1);

        // start+clear together while running at 23
        step(150);
        chk("run23", BCD_OUT, 8'h23);
        BTN_START_n = 1'b0;
        BTN_CLR_n = 1'b0;
        step(6);
        chk("run23b", BCD_OUT, 8'h23);
        BTN_START_n = 1'b1;
        BTN_CLR_n = 1'b1;
        step(1);
        chk_all("run_both", 8'h00, 1'b1, 1'b0);

        // pause at 23 then clear alone -> STOP
        step(226);
        chk("run22", BCD_OUT, 8'h22);
        BTN_START_n = 1'b0;
        step(6);
        BTN_START_n = 1'b1;
        step(1);
        chk_all("pause23", 8'h23, 1'b0, 1'b0);
        step(6);
        BTN_CLR_n = 1'b0;
        step(6);
        BTN_CLR_n = 1'b1;
        step(1);
        chk_all("pause_clr", 8'h00, 1'b0, 1'b0);
        step(20);
        chk_all("stopped", 8'h00, 1'b0, 1'b0);

        // clear in STOP has no effect
        BTN_CLR_n = 1'b0;
        step(6);
        BTN_CLR_n = 1'b1;
        step(1);
        chk_all("stop_clr", 8'h00, 1'b0, 1'b0);
        step(6);

        // start+clear in STOP -> RUN
        BTN_START_n = 1'b0;
        BTN_CLR_n = 1'b0;
        step(6);
        BTN_START_n = 1'b1;
        BTN_CLR_n = 1'b1;
        step(1);
        chk_all("stop_both", 8'h00, 1'b1, 1'b0);
        step(25);
        chk("run02", BCD_OUT, 8'h02);

        // async reset between clock edges
        #1 RST_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 1'b0);
        #1 RST_n = 1'b1;
        step(3);
        chk_all("post_rst", 8'h00, 1'b0, 1'b0);

        // start+clear in PAUSE -> RUN cleared
        BTN_START_n = 1'b0;
        step(6);
        BTN_START_n = 1'b1;
        step(1);
        chk("restart.run", 8'(RUNNING), 8'h01);
        step(14);
        BTN_START_n = 1'b0;
        step(6);
        BTN_START_n = 1'b1;
        step(1);
        chk_all("pause02", 8'h02, 1'b0, 1'b0);
        step(6);
        BTN_START_n = 1'b0;
        BTN_CLR_n = 1'b0;
        step(6);
        BTN_START_n = 1'b1;
        BTN_CLR_n = 1'b1;
        step(1);
        chk_all("pause_both", 8'h00, 1'b1, 1'b0);

`ifdef LAP_HOLD_EN
        step(134);
        BTN_LAP_n = 1'b0;
        step(6);
        BTN_LAP_n = 1'b1;
        step(1);
        chk_all("lap14", 8'h14, 1'b1, 1'b0);
        ntick = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            chk("lap.bcd", BCD_OUT, 8'h14);
            if (TICK) ntick++;
        end
        chk("lap.ticks", 8'(ntick), 8'd3);
        BTN_LAP_n = 1'b0;
        step(6);
        chk("lap.still", BCD_OUT, 8'h14);
        BTN_LAP_n = 1'b1;
        step(1);
        chk_all("lap_off", 8'h17, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
